// File: rtl/cpu_pkg.sv
// Shared LEGv8 decode definitions: immediate format select and the fixed
// instruction bit positions of every immediate and register field.
package cpu_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_D    = 3'd1,
    IMM_CB   = 3'd2,
    IMM_B    = 3'd3,
    IMM_IW   = 3'd4,
    IMM_NONE = 3'd5
  } imm_sel_t;

  localparam int IMM_I_LSB  = 10;
  localparam int IMM_I_W    = 12;
  localparam int IMM_D_LSB  = 12;
  localparam int IMM_D_W    = 9;
  localparam int IMM_CB_LSB = 5;
  localparam int IMM_CB_W   = 19;
  localparam int IMM_B_LSB  = 0;
  localparam int IMM_B_W    = 26;
  localparam int IMM_IW_LSB = 5;
  localparam int IMM_IW_W   = 16;
  localparam int IMM_HW_LSB = 21;
  localparam int IMM_HW_W   = 2;

  localparam int RD_LSB     = 0;
  localparam int RN_LSB     = 5;
  localparam int RM_LSB     = 16;
  localparam int REG_W      = 5;
  localparam int SHAMT_LSB  = 10;
  localparam int SHAMT_W    = 6;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extractor: picks the field named by imm_sel and
// zero- or sign-extends it to DATA_W. CB and B offsets stay unshifted.
module imm_gen
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [2:0]         imm_sel,
  output logic [DATA_W-1:0]  imm
);

  logic [DATA_W-1:0] iw_base;
  logic [5:0]        iw_shift;

  assign iw_base  = DATA_W'(instr[IMM_IW_LSB +: IMM_IW_W]);
  // MOVZ/MOVK halfword select: shift by 16 * hw
  assign iw_shift = {instr[IMM_HW_LSB +: IMM_HW_W], 4'b0000};

  always_comb begin
    imm = '0;
    case (imm_sel_t'(imm_sel))
      IMM_I:  imm = DATA_W'(instr[IMM_I_LSB +: IMM_I_W]);
      IMM_D:  imm = {{(DATA_W-IMM_D_W){instr[IMM_D_LSB+IMM_D_W-1]}},
                     instr[IMM_D_LSB +: IMM_D_W]};
      IMM_CB: imm = {{(DATA_W-IMM_CB_W){instr[IMM_CB_LSB+IMM_CB_W-1]}},
                     instr[IMM_CB_LSB +: IMM_CB_W]};
      IMM_B:  imm = {{(DATA_W-IMM_B_W){instr[IMM_B_LSB+IMM_B_W-1]}},
                     instr[IMM_B_LSB +: IMM_B_W]};
      IMM_IW: imm = iw_base << iw_shift;
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_imm_reg.sv
// ID/EX boundary register for the immediate and register specifiers.
// valid_out marks a real instruction; flush beats stall, stall beats load.
module id_ex_imm_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  input  logic [2:0]         imm_sel,
  input  logic               stall,
  input  logic               flush,
  output logic [DATA_W-1:0]  imm_out,
  output logic [4:0]         rd_out,
  output logic [4:0]         rn_out,
  output logic [4:0]         rm_out,
  output logic [5:0]         shamt_out,
  output logic               valid_out
);

  logic [DATA_W-1:0] imm_next;

  imm_gen #(
    .DATA_W  (DATA_W),
    .INSTR_W (INSTR_W)
  ) u_imm_gen (
    .instr   (instr),
    .imm_sel (imm_sel),
    .imm     (imm_next)
  );

  // A bubble (flush, or load with instr_valid=0) clears every field, not
  // just valid_out, so EX never sees stale specifiers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imm_out   <= '0;
      rd_out    <= '0;
      rn_out    <= '0;
      rm_out    <= '0;
      shamt_out <= '0;
      valid_out <= 1'b0;
    end else if (flush || (!stall && !instr_valid)) begin
      imm_out   <= '0;
      rd_out    <= '0;
      rn_out    <= '0;
      rm_out    <= '0;
      shamt_out <= '0;
      valid_out <= 1'b0;
    end else if (!stall) begin
      imm_out   <= imm_next;
      rd_out    <= instr[RD_LSB +: REG_W];
      rn_out    <= instr[RN_LSB +: REG_W];
      rm_out    <= instr[RM_LSB +: REG_W];
      shamt_out <= instr[SHAMT_LSB +: SHAMT_W];
      valid_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_imm_reg.sv
// Bench for id_ex_imm_reg: directed format/stall/flush/reset cases plus random
// traffic, checked through an expected-output queue against a behavioural model.
module tb_id_ex_imm_reg;

  localparam int EXP_W = 64 + 5 + 5 + 5 + 6 + 1;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic [2:0]  imm_sel;
  logic        stall;
  logic        flush;
  logic [63:0] imm_out;
  logic [4:0]  rd_out;
  logic [4:0]  rn_out;
  logic [4:0]  rm_out;
  logic [5:0]  shamt_out;
  logic        valid_out;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] model_q;
  int tests;
  int fails;

  id_ex_imm_reg dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .imm_sel     (imm_sel),
    .stall       (stall),
    .flush       (flush),
    .imm_out     (imm_out),
    .rd_out      (rd_out),
    .rn_out      (rn_out),
    .rm_out      (rm_out),
    .shamt_out   (shamt_out),
    .valid_out   (valid_out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_imm(input logic [31:0] i, input int sel);
    longint      v;
    longint      f;
    logic [63:0] u;
    v = 0;
    case (sel)
      0: v = longint'((i >> 10) & 32'hFFF);
      1: begin f = longint'((i >> 12) & 32'h1FF);     v = (f >= 256)      ? f - 512      : f; end
      2: begin f = longint'((i >> 5) & 32'h7FFFF);    v = (f >= 262144)   ? f - 524288   : f; end
      3: begin f = longint'(i & 32'h3FFFFFF);         v = (f >= 33554432) ? f - 67108864 : f; end
      4: begin
        u = 64'((i >> 5) & 32'hFFFF);
        u = u * (64'd1 << (16 * ((i >> 21) & 32'd3)));
        v = longint'(u);
      end
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  function automatic logic [EXP_W-1:0] model_next(input logic [31:0] i, input logic v,
                                                 input int sel, input logic st, input logic fl);
    if (fl)  return '0;
    if (st)  return model_q;
    if (!v)  return '0;
    return {model_imm(i, sel), 5'(i & 31), 5'((i >> 5) & 31), 5'((i >> 16) & 31),
            6'((i >> 10) & 63), 1'b1};
  endfunction

  function automatic logic [EXP_W-1:0] dut_out();
    return {imm_out, rd_out, rn_out, rm_out, shamt_out, valid_out};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = dut_out();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL pipe t=%0t got imm=%h rd=%0d rn=%0d rm=%0d sh=%0d v=%b exp imm=%h rd=%0d rn=%0d rm=%0d sh=%0d v=%b",
                 $time, g[85:22], g[21:17], g[16:12], g[11:7], g[6:1], g[0],
                 e[85:22], e[21:17], e[16:12], e[11:7], e[6:1], e[0]);
      end
    end
  end

  task automatic check_direct(input string name, input logic [EXP_W-1:0] exp);
    tests++;
    if (dut_out() !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, dut_out(), exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] i, input logic v, input int sel,
                       input logic st, input logic fl);
    logic [EXP_W-1:0] nxt;
    instr       = i;
    instr_valid = v;
    imm_sel     = 3'(sel);
    stall       = st;
    flush       = fl;
    nxt = model_next(i, v, sel, st, fl);
    @(posedge clk);
    model_q = nxt;
    exp_q.push_back(nxt);
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_direct("async_reset_immediate", '0);
    model_q = '0;
    instr = $urandom(); instr_valid = 1'b1; imm_sel = 3'd0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    exp_q.push_back('0);
    #1;
    reset_n = 1'b1;
    #1;
    check_direct("after_release", '0);
  endtask

  // Place a field value at lsb, filling the rest of the word with random bits.
  function automatic logic [31:0] put(input logic [31:0] val, input int lsb, input int w);
    logic [31:0] mask;
    mask = ((32'd1 << w) - 32'd1) << lsb;
    return ($urandom() & ~mask) | ((val << lsb) & mask);
  endfunction

  initial begin
    tests = 0; fails = 0; model_q = '0;
    reset_n = 1'b0; instr = '0; instr_valid = 1'b0; imm_sel = '0; stall = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_direct("reset_state", '0);
    reset_n = 1'b1;
    #1;
    check_direct("reset_release", '0);

    // immediate formats
    drive(put(32'hABC, 10, 12), 1, 0, 0, 0);
    drive(put(32'hFFF, 10, 12), 1, 0, 0, 0);
    drive(put(32'h1F0, 12, 9), 1, 1, 0, 0);
    drive(put(32'h3FFFF, 5, 19), 1, 2, 0, 0);
    drive(put(32'h40000, 5, 19), 1, 2, 0, 0);
    drive(put(32'h2000000, 0, 26), 1, 3, 0, 0);
    drive((put(32'h1234, 5, 16) & ~32'h0060_0000) | 32'h0040_0000, 1, 4, 0, 0);
    drive(put(32'h1234, 5, 16) | 32'h0060_0000, 1, 4, 0, 0);
    for (int s = 5; s < 8; s++) drive($urandom(), 1, s, 0, 0);

    // stall hold for three cycles, then release
    drive((put(32'h321, 10, 12) & ~32'h1F) | 32'd7, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive($urandom(), 1, $urandom_range(0, 4), 1, 0);
    drive($urandom(), 1, 0, 0, 0);

    // flush beats stall, and an invalid instruction loads a bubble
    drive($urandom(), 1, 1, 1, 1);
    drive($urandom(), 1, 2, 0, 0);
    drive($urandom(), 0, 2, 0, 0);

    // asynchronous reset while holding a real instruction
    drive(put(32'hABC, 10, 12), 1, 0, 0, 0);
    async_reset();
    drive(put(32'h5A5, 10, 12), 1, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 400; n++)
      drive($urandom(), ($urandom_range(0, 9) < 8), $urandom_range(0, 7),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));

    stall = 1'b0; flush = 1'b0; instr_valid = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #6;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_imm_reg.md
Name: id_ex_imm_reg

Overview:
Decode-to-execute boundary register for the 5-stage LEGv8 pipeline. It takes the raw 32-bit instruction from the IF/ID register and the decoder's immediate-format select. It extracts and extends the immediate to 64 bits, splits out the register specifiers, and registers everything into the EX stage. Stall holds the contents; flush inserts a bubble. EX/ALU operand muxing consumes the outputs directly.

Parameters:
DATA_W, 64, width of the extended immediate and datapath
INSTR_W, 32, instruction width

Ports:
clk  input  1  pipeline clock, rising-edge active
reset_n  input  1  asynchronous, active-low reset
instr  input  INSTR_W  instruction from IF/ID register
instr_valid  input  1  instr holds a real instruction (0 = bubble)
imm_sel  input  3  immediate format from decoder (imm_sel_t)
stall  input  1  hazard unit: hold current contents
flush  input  1  branch/hazard unit: replace contents with bubble
imm_out  output  DATA_W  extended immediate for EX
rd_out  output  5  instr[4:0]
rn_out  output  5  instr[9:5]
rm_out  output  5  instr[20:16]
shamt_out  output  6  instr[15:10]
valid_out  output  1  EX-stage contents are a real instruction

Behaviour:
- All outputs are registered. Latency is 1 clk from inputs to outputs. There is no combinational path from inputs to outputs.
- Reset (reset_n=0, asynchronous, takes effect immediately, including mid-stall): all outputs 0, valid_out=0. The first capture occurs on the first rising edge after reset_n rises.
- Per-edge priority: flush > stall > load.
  - flush=1: all outputs <= 0, valid_out <= 0. This applies regardless of stall.
  - stall=1, flush=0: every output holds its value, including valid_out.
  - Otherwise load: if instr_valid=1, capture the fields below and set valid_out <= 1. If instr_valid=0, load the bubble (all 0, valid_out=0).
- Immediate generation, combinational inside the stage, by imm_sel:
  - I (0): zero-extend instr[21:10] (12 bits).
  - D (1): sign-extend instr[20:12] (9 bits).
  - CB (2): sign-extend instr[23:5] (19 bits). The result is an unshifted word offset; the branch unit applies the <<2.
  - B (3): sign-extend instr[25:0] (26 bits), unshifted.
  - IW (4): zero-extend instr[20:5] (16 bits), then shift left by 16*instr[22:21]. hw=3 places imm16 at bits [63:48].
  - 5–7 (NONE): imm_out = 0.
- Sign extension replicates the field's MSB into every bit up to DATA_W-1.
- Register fields are captured unconditionally from their fixed bit positions on load, independent of imm_sel.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef enum logic [2:0] imm_sel_t {IMM_I, IMM_D, IMM_CB, IMM_B, IMM_IW, IMM_NONE}
  - field-position localparams for the immediate fields, rd, rn, rm and shamt
- Sub-module imm_gen is purely combinational: (instr, imm_sel) -> 64-bit immediate. id_ex_imm_reg instantiates imm_gen and holds only the register, stall and flush logic.
- imm_gen is unit-testable on its own.

Test Plan:
- I-format: instr[21:10]=12'hABC, imm_sel=IMM_I, valid=1 -> next edge imm_out=64'h0000_0000_0000_0ABC, valid_out=1. With instr[21:10]=12'hFFF -> 64'h0000_0000_0000_0FFF (no sign extension).
- D and CB sign extension:
  - instr[20:12]=9'h1F0, IMM_D -> imm_out=64'hFFFF_FFFF_FFFF_FFF0.
  - instr[23:5]=19'h3FFFF, IMM_CB -> 64'h0000_0000_0003_FFFF.
  - instr[23:5]=19'h40000, IMM_CB -> 64'hFFFF_FFFF_FFFC_0000.
- IW shift: instr[20:5]=16'h1234, instr[22:21]=2'd2, IMM_IW -> imm_out=64'h0000_1234_0000_0000. With hw=3 -> 64'h1234_0000_0000_0000.
- Stall hold: load I-format imm 12'h321 and rd=5'd7, then assert stall for 3 cycles while changing instr -> imm_out stays 64'h321, rd_out stays 7, valid_out stays 1. After stall drops, the new instr appears 1 edge later.
- Flush priority: assert stall=1 and flush=1 together while valid_out=1 -> next edge all outputs 0, valid_out=0. Also drive instr_valid=0 with stall=0, flush=0 -> bubble loaded.
- Async reset: drop reset_n mid-cycle between edges while valid_out=1, imm_out=64'hABC -> outputs go to 0 immediately without waiting for clk. Release reset_n -> outputs stay 0 until the next loading edge.
